// File: rtl/vga_pkg.sv
// Shared VGA timing constants. Pixel generators import the same offsets so their
// coordinate decode lines up with the sync generator.
package vga_pkg;

    // Counter and colour widths
    localparam int CNT_W   = 10;
    localparam int COLOR_W = 3;

    // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;   // 800
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;   // 525

    // First visible column / line, counted from the start of the sync pulse
    localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;                        // 144
    localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;                        // 35

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/clk_en_div.sv
// Free-running clock-enable divider. tick marks the last board clock of each
// period, first marks the first one. With DIV = 1 both are constantly high.
module clk_en_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic first
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] div;

    // Count 0..DIV-1, restarting from 0 on reset
    always_ff @(posedge clk) begin
        if (rst || div == LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick  = (div == LAST);
    assign first = (div == '0);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel/line counters, sync and display-enable decode, and a
// registered output stage that keeps colour and sync pins aligned (1 clk after the
// counter value that produced them).
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = 1,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter bit SYNC_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [CNT_W-1:0]   h_count,
    output logic [CNT_W-1:0]   v_count,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] rgb_r,
    input  logic [COLOR_W-1:0] rgb_g,
    input  logic [COLOR_W-1:0] rgb_b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Compares are done one bit wider so an area ending exactly at 1024 still works
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W:0]   H_SYN_E = (CNT_W+1)'(H_SYNC);
    localparam logic [CNT_W:0]   V_SYN_E = (CNT_W+1)'(V_SYNC);
    localparam logic [CNT_W:0]   H_ACT_S = (CNT_W+1)'(H_SYNC + H_BP);
    localparam logic [CNT_W:0]   H_ACT_E = (CNT_W+1)'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACT_S = (CNT_W+1)'(V_SYNC + V_BP);
    localparam logic [CNT_W:0]   V_ACT_E = (CNT_W+1)'(V_SYNC + V_BP + V_ACTIVE);

    // Counters are CNT_W bits wide, so a frame larger than 1024x1024 cannot be counted
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    logic pix_first;
    logic hs_int;
    logic vs_int;
    logic de;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk   (clk),
        .rst   (rst),
        .tick  (pix_tick),
        .first (pix_first)
    );

    // Pixel and line counters; both advance only on the pixel tick
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Sync, display-enable and start-pulse decode from the current counter values
    always_comb begin
        hs_int      = ({1'b0, h_count} < H_SYN_E);
        vs_int      = ({1'b0, v_count} < V_SYN_E);
        de          = ({1'b0, h_count} >= H_ACT_S) && ({1'b0, h_count} < H_ACT_E) &&
                      ({1'b0, v_count} >= V_ACT_S) && ({1'b0, v_count} < V_ACT_E);
        // Gated by rst so the pulses stay quiet while reset holds the counters at 0,0
        line_start  = !rst && pix_first && (h_count == '0);
        frame_start = line_start && (v_count == '0);
    end

    // Output register: blanked colour plus sync pins, one clk behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= SYNC_ACT_LOW;
            vga_vs <= SYNC_ACT_LOW;
        end else begin
            vga_r  <= de ? rgb_r : '0;
            vga_g  <= de ? rgb_g : '0;
            vga_b  <= de ? rgb_b : '0;
            vga_hs <= hs_int ^ SYNC_ACT_LOW;
            vga_vs <= vs_int ^ SYNC_ACT_LOW;
        end
    end

endmodule
